// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
// Redirect sources are encoded in priority order so a single select drives the target mux.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h8000_0004;
  localparam int          KILL_W       = 16;

  typedef enum logic [1:0] {
    REDIR_EXC = 2'd0,
    REDIR_BR  = 2'd1,
    REDIR_J   = 2'd2,
    REDIR_SEQ = 2'd3
  } redir_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  function automatic redir_sel_e redir_sel(input logic exc, input logic br, input logic j);
    if (exc)     return REDIR_EXC;
    else if (br) return REDIR_BR;
    else if (j)  return REDIR_J;
    return REDIR_SEQ;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_slot_fifo.sv
// In-order ring of fetch slots: reserved at tail on grant, filled oldest-first on response,
// popped at head; a sync clear drops everything on redirect.
module fetch_slot_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_rsv,
  input  logic [31:0]              i_rsv_pc,
  input  logic                     i_fill,
  input  logic [31:0]              i_fill_instr,
  input  logic                     i_pop,
  output logic                     o_head_vld,
  output logic [31:0]              o_head_pc,
  output logic [31:0]              o_head_instr,
  output logic [$clog2(DEPTH):0]   o_cnt
);
  localparam int AW = $clog2(DEPTH);

  slot_t            r_slot [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [AW-1:0]    r_head, r_tail, r_fptr;
  logic [AW:0]      r_cnt;

  // Reserve, fill and pop never hit the same index in one cycle: the top only
  // reserves when not full, fills only unfilled slots and pops only a filled head.
  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_filled <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_fptr   <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_rsv) begin
        r_slot[r_tail].pc <= i_rsv_pc;
        r_filled[r_tail]  <= 1'b0;
        r_tail            <= r_tail + AW'(1);
      end
      if (i_fill) begin
        r_slot[r_fptr].instr <= i_fill_instr;
        r_filled[r_fptr]     <= 1'b1;
        r_fptr               <= r_fptr + AW'(1);
      end
      if (i_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + AW'(1);
      end
      r_cnt <= r_cnt + (AW+1)'(i_rsv) - (AW+1)'(i_pop);
    end
  end

  assign o_head_vld   = r_filled[r_head];
  assign o_head_pc    = r_slot[r_head].pc;
  assign o_head_instr = r_slot[r_head].instr;
  assign o_cnt        = r_cnt;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage producer: owns fetch PC, issues in-order imem requests, buffers responses and
// presents one instruction per cycle to IF/ID; drops wrong-path responses after a redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC    = DEF_EXC_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        exc_redirect,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        j_redirect,
  input  logic [31:0] j_target,
  input  logic        IF_ID_Wr,
  output logic        inst_valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC_out,
  output logic [31:0] PC_plus4
);
  localparam int AW = $clog2(BUF_DEPTH);

  logic [31:0]       r_fetch_pc;
  logic [AW:0]       r_outstanding;
  logic [KILL_W-1:0] r_kill_cnt;

  redir_sel_e        w_sel;
  logic              w_redir, w_grant, w_rsp_kill, w_fill, w_pop;
  logic [31:0]       w_target;
  logic [AW:0]       w_cnt, w_out_nxt;
  logic [KILL_W-1:0] w_kill_after;
  logic              w_head_vld;
  logic [31:0]       w_head_pc, w_head_instr;

  assign w_sel   = redir_sel(exc_redirect, br_redirect, j_redirect);
  assign w_redir = (w_sel != REDIR_SEQ);

  always_comb begin
    w_target = r_fetch_pc;
    case (w_sel)
      REDIR_EXC: w_target = EXC_PC;
      REDIR_BR:  w_target = br_target;
      REDIR_J:   w_target = j_target;
      default:   w_target = r_fetch_pc;
    endcase
  end

  assign imem_req  = reset && !w_redir && (w_cnt < (AW+1)'(BUF_DEPTH));
  assign imem_addr = {r_fetch_pc[31:2], 2'b00};

  assign w_grant      = imem_req && imem_gnt;
  assign w_rsp_kill   = imem_rvalid && (r_kill_cnt != '0);
  assign w_fill       = imem_rvalid && (r_kill_cnt == '0) && (r_outstanding != '0);
  assign w_pop        = w_head_vld && IF_ID_Wr && !w_redir;
  assign w_out_nxt    = r_outstanding + (AW+1)'(w_grant) - (AW+1)'(w_fill);
  assign w_kill_after = r_kill_cnt - KILL_W'(w_rsp_kill);

  // On redirect every response still in flight (live or already doomed) must be dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_kill_cnt    <= '0;
    end else if (w_redir) begin
      r_fetch_pc    <= w_target;
      r_outstanding <= '0;
      r_kill_cnt    <= w_kill_after + KILL_W'(w_out_nxt);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= w_out_nxt;
      r_kill_cnt    <= w_kill_after;
    end
  end

  fetch_slot_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_redir),
    .i_rsv        (w_grant),
    .i_rsv_pc     (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_instr (imem_rdata),
    .i_pop        (w_pop),
    .o_head_vld   (w_head_vld),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr),
    .o_cnt        (w_cnt)
  );

  assign inst_valid  = w_head_vld;
  assign Instruction = w_head_vld ? w_head_instr : NOP_INSTR;
  assign PC_out      = w_head_vld ? w_head_pc : 32'h0;
  assign PC_plus4    = w_head_vld ? (w_head_pc + 32'd4) : 32'h0;

  a_rsp_orphan: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid && (r_kill_cnt == '0) && (r_outstanding == '0)));

endmodule
